// File: rtl/stream_pkg.sv
// Shared types and default widths for the valid/ready stream blocks (source, register slice, sink).
// The GAP state is only reachable when STREAM_SOURCE_THROTTLE_EN is defined.
package stream_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 16;
  localparam int GAP_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic                  last;
  } beat_t;

endpackage

// File: rtl/stream_source_if.sv
// Valid/ready stream bundle; the producer uses the master modport and the consumer uses the slave modport.
interface stream_source_if import stream_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/stream_gap_timer.sv
// Idle-gap countdown for stream_source, used only when STREAM_SOURCE_THROTTLE_EN is defined.
// After a load of N, expire is high during the N-th cycle that follows.
module stream_gap_timer import stream_pkg::*; #(
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [GAP_W-1:0] value,
  output logic             expire
);

  logic [GAP_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == GAP_W'(1));

endmodule

// File: rtl/stream_source.sv
// Burst generator: drives len beats of base + k*step onto a valid/ready stream, then pulses done.
// Defining STREAM_SOURCE_THROTTLE_EN adds the gap port and inserts idle cycles after each beat.
module stream_source import stream_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
`ifdef STREAM_SOURCE_THROTTLE_EN
  , parameter int GAP_W = GAP_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] base,
  input  logic [DATA_W-1:0] step,
`ifdef STREAM_SOURCE_THROTTLE_EN
  input  logic [GAP_W-1:0]  gap,
`endif
  stream_source_if.master   m,
  output logic              busy,
  output logic              done
);

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  k_q;
  logic [DATA_W-1:0] step_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              last_q;
  logic              xfer;
  logic [LEN_W-1:0]  k_next;
  logic              last_next;

  assign xfer      = valid_q & m.ready;
  assign k_next    = k_q + 1'b1;
  assign last_next = (k_next == len_q - 1'b1);

  assign m.valid = valid_q;
  assign m.data  = data_q;
  assign m.last  = last_q;

`ifdef STREAM_SOURCE_THROTTLE_EN
  logic [GAP_W-1:0] gap_q;
  logic             gap_load;
  logic             gap_expire;

  assign gap_load = (state == SEND) && xfer && !last_q && (gap_q != '0);

  stream_gap_timer #(.GAP_W(GAP_W)) u_gap_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (gap_load),
    .value  (gap_q),
    .expire (gap_expire)
  );
`endif

  // data_q doubles as the accumulator, so each beat costs one adder rather than a multiplier.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      len_q   <= '0;
      k_q     <= '0;
      step_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef STREAM_SOURCE_THROTTLE_EN
      gap_q   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len_q  <= len;
            step_q <= step;
            k_q    <= '0;
            data_q <= base;
`ifdef STREAM_SOURCE_THROTTLE_EN
            gap_q  <= gap;
`endif
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= SEND;
              busy    <= 1'b1;
              valid_q <= 1'b1;
              last_q  <= (len == LEN_W'(1));
            end
          end
        end
        SEND: begin
          if (xfer) begin
            k_q    <= k_next;
            data_q <= data_q + step_q;
            last_q <= last_next;
            if (last_q) begin
              state   <= DONE;
              busy    <= 1'b0;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done    <= 1'b1;
            end
`ifdef STREAM_SOURCE_THROTTLE_EN
            else if (gap_q != '0) begin
              state   <= GAP;
              valid_q <= 1'b0;
            end
`endif
          end
        end
`ifdef STREAM_SOURCE_THROTTLE_EN
        GAP: begin
          if (gap_expire) begin
            state   <= SEND;
            valid_q <= 1'b1;
          end
        end
`endif
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_source.sv
// Self-checking bench for stream_source: vector table, directed corner sequences and a randomized model check.
// Throttle sequences run only when STREAM_SOURCE_THROTTLE_EN is defined.
module tb_stream_source;
  import stream_pkg::*;

  localparam int DW = 8;
  localparam int LW = 8;
  localparam int GW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic [DW-1:0] base = '0;
  logic [DW-1:0] step = '0;
  logic          busy;
  logic          done;
`ifdef STREAM_SOURCE_THROTTLE_EN
  logic [GW-1:0] gap = '0;
`endif

  int errors = 0;
  int checks = 0;

  stream_source_if #(.DATA_W(DW)) sif ();

  stream_source #(
    .DATA_W (DW),
    .LEN_W  (LW)
`ifdef STREAM_SOURCE_THROTTLE_EN
    , .GAP_W (GW)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .len   (len),
    .base  (base),
    .step  (step),
`ifdef STREAM_SOURCE_THROTTLE_EN
    .gap   (gap),
`endif
    .m     (sif.master),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]      len;
    logic [7:0]      base;
    logic [7:0]      step;
    logic [3:0][7:0] exp;
  } vec_t;

  function automatic vec_t mk(int l, int b, int s, int e0, int e1, int e2, int e3);
    vec_t v;
    v.len = 8'(l);
    v.base = 8'(b);
    v.step = 8'(s);
    v.exp = {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Launch one burst with ready held high and check every beat plus the done pulse.
  task automatic apply_stimulus(input vec_t v);
    len = v.len;
    base = v.base;
    step = v.step;
    start = 1'b1;
    sif.ready = 1'b1;
    tick();
    start = 1'b0;
    base = 8'($urandom);
    step = 8'($urandom);
    len = 8'($urandom);
    for (int i = 0; i < int'(v.len); i++) begin
      check_output("beat_valid", 32'(sif.valid), 32'd1);
      check_output("beat_busy", 32'(busy), 32'd1);
      check_output("beat_data", 32'(sif.data), 32'(v.exp[i]));
      check_output("beat_last", 32'(sif.last), (i == int'(v.len) - 1) ? 32'd1 : 32'd0);
      tick();
    end
    check_output("done_pulse", 32'(done), 32'd1);
    check_output("done_valid", 32'(sif.valid), 32'd0);
    check_output("done_busy", 32'(busy), 32'd0);
    tick();
    check_output("done_clear", 32'(done), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int    idx;
    int    cycles;
    int    l;
    int    b;
    int    s;
    int    prev_stall;
    int    prev_data;
    logic  r;

    vecs[0] = mk(4, 10, 3, 10, 13, 16, 19);
    vecs[1] = mk(3, 250, 4, 250, 254, 2, 0);
    vecs[2] = mk(0, 55, 1, 0, 0, 0, 0);
    vecs[3] = mk(1, 7, 9, 7, 0, 0, 0);
    vecs[4] = mk(4, 255, 255, 255, 254, 253, 252);
    vecs[5] = mk(2, 0, 128, 0, 128, 0, 0);

    sif.ready = 1'b1;
    #12;
    check_output("reset_valid", 32'(sif.valid), 32'd0);
    check_output("reset_data", 32'(sif.data), 32'd0);
    check_output("reset_last", 32'(sif.last), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) apply_stimulus(vecs[i]);

    // Backpressure: beat 1 is stalled for three cycles and must stay put.
    len = 3; base = 0; step = 1; start = 1'b1; sif.ready = 1'b1;
    tick();
    start = 1'b0;
    check_output("bp_beat0", 32'(sif.data), 32'd0);
    tick();
    sif.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_output("bp_hold_valid", 32'(sif.valid), 32'd1);
      check_output("bp_hold_data", 32'(sif.data), 32'd1);
      check_output("bp_hold_last", 32'(sif.last), 32'd0);
      tick();
    end
    sif.ready = 1'b1;
    check_output("bp_beat1", 32'(sif.data), 32'd1);
    tick();
    check_output("bp_beat2", 32'(sif.data), 32'd2);
    check_output("bp_beat2_last", 32'(sif.last), 32'd1);
    tick();
    check_output("bp_done", 32'(done), 32'd1);
    tick();

    // Start pulsed mid-burst must not disturb the running burst.
    len = 4; base = 20; step = 5; start = 1'b1;
    tick();
    start = 1'b0;
    check_output("ign_beat0", 32'(sif.data), 32'd20);
    tick();
    check_output("ign_beat1", 32'(sif.data), 32'd25);
    len = 1; base = 99; step = 1; start = 1'b1;
    tick();
    start = 1'b0;
    check_output("ign_beat2", 32'(sif.data), 32'd30);
    check_output("ign_busy", 32'(busy), 32'd1);
    tick();
    check_output("ign_beat3", 32'(sif.data), 32'd35);
    check_output("ign_last", 32'(sif.last), 32'd1);
    tick();
    check_output("ign_done", 32'(done), 32'd1);
    tick();
    check_output("ign_no_relaunch", 32'(sif.valid), 32'd0);

    // Reset during beat 2 of an 8-beat burst clears outputs asynchronously.
    len = 8; base = 40; step = 2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check_output("abort_beat2", 32'(sif.data), 32'd44);
    reset = 1'b0;
    #1;
    check_output("abort_valid", 32'(sif.valid), 32'd0);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    apply_stimulus(mk(2, 100, 1, 100, 101, 0, 0));

`ifdef STREAM_SOURCE_THROTTLE_EN
    // Throttle: gap=2, len=3 gives valid pattern 1,0,0,1,0,0,1.
    len = 3; base = 1; step = 1; gap = 2; start = 1'b1;
    tick();
    start = 1'b0;
    gap = 0;
    for (int i = 0; i < 7; i++) begin
      check_output("gap_valid", 32'(sif.valid), (i % 3 == 0) ? 32'd1 : 32'd0);
      if (i % 3 == 0) check_output("gap_data", 32'(sif.data), 32'(1 + i / 3));
      tick();
    end
    check_output("gap_done", 32'(done), 32'd1);
    tick();
`endif

    // Random bursts with random backpressure against a per-beat arithmetic model.
    for (int n = 0; n < 40; n++) begin
      l = $urandom_range(0, 6);
      b = $urandom_range(0, 255);
      s = $urandom_range(0, 255);
      len = 8'(l); base = 8'(b); step = 8'(s); start = 1'b1;
`ifdef STREAM_SOURCE_THROTTLE_EN
      gap = 4'($urandom_range(0, 2));
`endif
      tick();
      start = 1'b0;
      base = 8'($urandom);
      step = 8'($urandom);
      idx = 0;
      cycles = 0;
      prev_stall = 0;
      prev_data = 0;
      while (!done && cycles < 200) begin
        if (prev_stall != 0) begin
          check_output("rnd_hold_valid", 32'(sif.valid), 32'd1);
          check_output("rnd_hold_data", 32'(sif.data), 32'(prev_data));
        end
        if (sif.valid) begin
          if (idx < l) begin
            check_output("rnd_data", 32'(sif.data), 32'((b + idx * s) % 256));
            check_output("rnd_last", 32'(sif.last), (idx == l - 1) ? 32'd1 : 32'd0);
          end else begin
            check_output("rnd_extra_beat", 32'(idx), 32'(l - 1));
          end
        end
        r = ($urandom_range(0, 9) < 7);
        sif.ready = r;
        if (sif.valid && r) idx++;
        prev_stall = (sif.valid && !r) ? 1 : 0;
        prev_data = int'(sif.data);
        tick();
        cycles++;
      end
      check_output("rnd_done_seen", 32'(done), 32'd1);
      check_output("rnd_beat_count", 32'(idx), 32'(l));
      check_output("rnd_done_valid", 32'(sif.valid), 32'd0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
